// File: rtl/lsu_pkg.sv
// lsu_pkg
//   Shared definitions for the load/store unit: RV32I load/store funct3
//   encodings, the two-state split FSM type and byte-count helpers used to
//   decide how many byte accesses a misaligned request is broken into.

package lsu_pkg;

    // RV32I load funct3 encodings
    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;

    // Store byte shares its encoding with LB; named separately for readability
    localparam logic [2:0] F3_SB  = 3'd0;

    // Byte counts per access size
    localparam logic [2:0] BYTES_BYTE = 3'd1;
    localparam logic [2:0] BYTES_HALF = 3'd2;
    localparam logic [2:0] BYTES_WORD = 3'd4;

    typedef enum logic {
        IDLE  = 1'b0,
        SPLIT = 1'b1
    } lsu_state_t;

    // Access size in bytes, taken from funct3[1:0] (signedness bit ignored)
    function automatic logic [2:0] access_bytes(input logic [2:0] f3);
        case (f3[1:0])
            2'd1:    return BYTES_HALF;
            2'd2:    return BYTES_WORD;
            default: return BYTES_BYTE;
        endcase
    endfunction

    // funct3 values 3, 6 and 7 do not describe a load/store
    function automatic logic f3_valid(input logic [2:0] f3);
        return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
               (f3 == F3_LBU) || (f3 == F3_LHU);
    endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// lsu_load_extend
//   Combinational sign/zero extension of an assembled split-load value.
//   Used only for split loads; aligned loads are extended by DataMemory.
// Ports:
//   func3  in  3   latched load funct3
//   raw    in  32  assembled bytes, byte 0 in bits [7:0]
//   ext    out 32  extended load result

module lsu_load_extend
    import lsu_pkg::*;
(
    input  logic [2:0]  func3,
    input  logic [31:0] raw,
    output logic [31:0] ext
);

    always_comb begin
        ext = raw;
        case (func3)
            F3_LB:   ext = {{24{raw[7]}}, raw[7:0]};
            F3_LBU:  ext = {24'b0, raw[7:0]};
            F3_LH:   ext = {{16{raw[15]}}, raw[15:0]};
            F3_LHU:  ext = {16'b0, raw[15:0]};
            default: ext = raw;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit
//   Memory-stage front end between EX/MEM and DataMemory. Aligned accesses
//   pass straight through combinationally. Misaligned halfword/word accesses
//   are split into sequential byte accesses (LBU/SB), stalling the pipeline
//   until the last byte; split load bytes are assembled and extended here.
//
//   Optional feature macro: LSU_MISALIGN_TRAP_EN
//     defined   - misaligned requests are not split; they issue no access
//                 and raise misalign_err for that cycle.
//     undefined - splitting enabled; misalign_err tied to 0.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   mem_read, mem_write      request from EX/MEM (write wins if both set)
//   func3, addr, wdata       request funct3, byte address, store data
//   flush                    abandon a split access in progress
//   dmem_read/write/func3/addr/wdata   request to DataMemory
//   dmem_rdata               combinational read data from DataMemory
//   load_data                extended load result to MEM/WB
//   stall                    freezes the front of the pipeline
//   misalign_err             misaligned access trapped (macro only)

module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [2:0]        func3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              flush,
    output logic              dmem_read,
    output logic              dmem_write,
    output logic [2:0]        dmem_func3,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic [DATA_W-1:0] load_data,
    output logic              stall,
    output logic              misalign_err
);

    lsu_state_t        state_q, state_d;
    logic [1:0]        k_q, k_d;
    logic [1:0]        last_q, last_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        func3_q, func3_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              write_q, write_d;
    logic [DATA_W-1:0] asm_q, asm_d;

    logic              req_valid;
    logic              req_store;
    logic              req_load;
    logic              req_misaligned;
    logic [2:0]        req_bytes;
    logic [4:0]        lane_lsb;
    logic [DATA_W-1:0] asm_now;
    logic [DATA_W-1:0] split_load;

    // Request decode; a simultaneous read and write is treated as a write
    always_comb begin
        req_valid      = (mem_read || mem_write) && f3_valid(func3);
        req_store      = req_valid && mem_write;
        req_load       = req_valid && !mem_write;
        req_bytes      = access_bytes(func3);
        req_misaligned = req_valid &&
                         (((req_bytes == BYTES_WORD) && (addr[1:0] != 2'b00)) ||
                          ((req_bytes == BYTES_HALF) && addr[0]));
    end

    // Assembly register with the byte currently on the bus merged into lane k,
    // so the final cycle can extend the complete value without waiting a clock
    always_comb begin
        lane_lsb = {k_q, 3'b000};
        asm_now  = asm_q;
        asm_now[lane_lsb +: 8] = dmem_rdata[7:0];
    end

    lsu_load_extend u_extend (
        .func3 (func3_q),
        .raw   (asm_now),
        .ext   (split_load)
    );

    // Next-state logic. Byte 0 is issued in the IDLE cycle, so SPLIT starts at k=1
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        last_d  = last_q;
        addr_d  = addr_q;
        func3_d = func3_q;
        wdata_d = wdata_q;
        write_d = write_q;
        asm_d   = asm_q;
        case (state_q)
            IDLE: begin
`ifndef LSU_MISALIGN_TRAP_EN
                if (req_misaligned) begin
                    state_d = SPLIT;
                    addr_d  = addr;
                    func3_d = func3;
                    wdata_d = wdata;
                    write_d = req_store;
                    last_d  = 2'(req_bytes - 3'd1);
                    k_d     = 2'd1;
                    asm_d   = '0;
                    if (req_load) begin
                        asm_d[7:0] = dmem_rdata[7:0];
                    end
                end
`endif
            end
            SPLIT: begin
                if (flush || (k_q == last_q)) begin
                    state_d = IDLE;
                    k_d     = '0;
                    asm_d   = '0;
                end else begin
                    k_d = k_q + 2'd1;
                    if (!write_q) begin
                        asm_d = asm_now;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            last_q  <= '0;
            addr_q  <= '0;
            func3_q <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            asm_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            func3_q <= func3_d;
            wdata_q <= wdata_d;
            write_q <= write_d;
            asm_q   <= asm_d;
        end
    end

    // Output logic; everything is forced to zero while reset is asserted.
    // In SPLIT only latched fields are used, so EX/MEM changes are ignored.
    always_comb begin
        dmem_read    = 1'b0;
        dmem_write   = 1'b0;
        dmem_func3   = '0;
        dmem_addr    = '0;
        dmem_wdata   = '0;
        load_data    = '0;
        stall        = 1'b0;
        misalign_err = 1'b0;
        if (!rst) begin
            if (state_q == SPLIT) begin
                dmem_read  = !write_q;
                dmem_write = write_q;
                dmem_func3 = write_q ? F3_SB : F3_LBU;
                dmem_addr  = addr_q + ADDR_W'(k_q);
                dmem_wdata = DATA_W'(wdata_q[lane_lsb +: 8]);
                stall      = (k_q != last_q);
                if (!write_q && (k_q == last_q)) begin
                    load_data = split_load;
                end
            end else if (req_misaligned) begin
`ifdef LSU_MISALIGN_TRAP_EN
                misalign_err = 1'b1;
`else
                dmem_read  = req_load;
                dmem_write = req_store;
                dmem_func3 = req_store ? F3_SB : F3_LBU;
                dmem_addr  = addr;
                dmem_wdata = DATA_W'(wdata[7:0]);
                stall      = 1'b1;
`endif
            end else begin
                dmem_read  = req_load;
                dmem_write = req_store;
                dmem_func3 = func3;
                dmem_addr  = addr;
                dmem_wdata = wdata;
                if (req_load) begin
                    load_data = dmem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit
//   Self-checking bench for load_store_unit. A byte-array DataMemory model
//   (256 bytes, indexed by addr[7:0]) sits behind the DUT. A shadow memory
//   and plain-arithmetic reference predict, per transaction, the number of
//   cycles, the load result and the memory image. Directed cases cover the
//   documented scenarios; a randomized loop follows.

module tb_load_store_unit;

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  func3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        flush;
    logic        dmem_read;
    logic        dmem_write;
    logic [2:0]  dmem_func3;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic [31:0] load_data;
    logic        stall;
    logic        misalign_err;

    logic [7:0]  mem     [0:255];
    logic [7:0]  ref_mem [0:255];
    logic        mem_init;
    logic        poke_en;
    logic [7:0]  poke_addr;
    logic [7:0]  poke_data;
    logic [7:0]  b0, b1, b2, b3;

    int          checks;
    int          errors;
    int          last_cycles;
    logic [31:0] last_load;

    load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .func3        (func3),
        .addr         (addr),
        .wdata        (wdata),
        .flush        (flush),
        .dmem_read    (dmem_read),
        .dmem_write   (dmem_write),
        .dmem_func3   (dmem_func3),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_rdata   (dmem_rdata),
        .load_data    (load_data),
        .stall        (stall),
        .misalign_err (misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] initPat(input int i);
        return 8'((i * 37 + 11) & 255);
    endfunction

    // DataMemory model: combinational extended read
    assign b0 = mem[dmem_addr[7:0]];
    assign b1 = mem[dmem_addr[7:0] + 8'd1];
    assign b2 = mem[dmem_addr[7:0] + 8'd2];
    assign b3 = mem[dmem_addr[7:0] + 8'd3];

    always_comb begin
        case (dmem_func3)
            3'd0:    dmem_rdata = {{24{b0[7]}}, b0};
            3'd1:    dmem_rdata = {{16{b1[7]}}, b1, b0};
            3'd2:    dmem_rdata = {b3, b2, b1, b0};
            3'd4:    dmem_rdata = {24'b0, b0};
            3'd5:    dmem_rdata = {16'b0, b1, b0};
            default: dmem_rdata = 32'b0;
        endcase
    end

    // DataMemory model: writes committed at posedge
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= initPat(i);
        end else if (poke_en) begin
            mem[poke_addr] <= poke_data;
        end else if (dmem_write) begin
            mem[dmem_addr[7:0]] <= dmem_wdata[7:0];
            if (dmem_func3[1:0] != 2'd0) mem[dmem_addr[7:0] + 8'd1] <= dmem_wdata[15:8];
            if (dmem_func3[1:0] == 2'd2) begin
                mem[dmem_addr[7:0] + 8'd2] <= dmem_wdata[23:16];
                mem[dmem_addr[7:0] + 8'd3] <= dmem_wdata[31:24];
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] refExtend(input logic [2:0] f3, input logic [31:0] raw);
        case (f3)
            3'd0:    return 32'($signed(raw[7:0]));
            3'd1:    return 32'($signed(raw[15:0]));
            3'd4:    return {24'b0, raw[7:0]};
            3'd5:    return {16'b0, raw[15:0]};
            default: return raw;
        endcase
    endfunction

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        poke_en = 1'b1; poke_addr = a; poke_data = d;
        @(negedge clk);
        poke_en = 1'b0;
        ref_mem[a] = d;
    endtask

    // Drive one request, hold it while stalled, check against the reference
    task automatic applyStimulus(input logic rd, input logic wr, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] wd);
        logic        valid, is_store, is_load, mis, trapped;
        int          nb, exp_cycles, cyc;
        logic [31:0] raw, exp_load;
        logic        done, first_err, first_read;

        valid    = (rd || wr) && (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        is_store = valid && wr;
        is_load  = valid && !wr;
        nb       = (f3[1:0] == 2'd2) ? 4 : (f3[1:0] == 2'd1) ? 2 : 1;
        mis      = valid && (((nb == 4) && (a % 4 != 0)) || ((nb == 2) && (a % 2 != 0)));
        trapped  = mis && TRAP;
        exp_cycles = (mis && !TRAP) ? nb : 1;
        raw = 32'b0;
        for (int i = 0; i < nb; i++) raw[8*i +: 8] = ref_mem[8'(a[7:0] + 8'(i))];
        exp_load = (is_load && !trapped) ? refExtend(f3, raw) : 32'b0;

        @(negedge clk);
        mem_read = rd; mem_write = wr; func3 = f3; addr = a; wdata = wd;
        cyc = 0; done = 1'b0; first_err = 1'b0; first_read = 1'b0; last_load = 32'b0;
        while (!done && cyc < 8) begin
            #1;
            if (cyc == 0) begin
                first_err  = misalign_err;
                first_read = dmem_read;
            end
            cyc++;
            if (!stall) begin
                last_load = load_data;
                done = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        last_cycles = cyc;
        @(posedge clk);
        #1;
        mem_read = 1'b0; mem_write = 1'b0;

        checkOutput("cycles", 32'(cyc), 32'(exp_cycles));
        checkOutput("merr", {31'b0, first_err}, {31'b0, trapped});
        checkOutput("dread", {31'b0, first_read}, {31'b0, is_load && !trapped});
        if (rd && !wr) checkOutput("load", last_load, exp_load);
        if (is_store && !trapped) begin
            for (int i = 0; i < nb; i++) ref_mem[8'(a[7:0] + 8'(i))] = wd[8*i +: 8];
        end
    endtask

    initial begin
        int          diffs;
        int          r;
        logic [2:0]  f3_tab [0:9];
        logic [2:0]  f3;
        logic        rd, wr;

        checks = 0; errors = 0;
        f3_tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd1, 3'd2, 3'd3, 3'd6, 3'd7};
        rst = 1'b1; mem_read = 1'b1; mem_write = 1'b0; func3 = 3'd2; addr = 32'h3;
        wdata = 32'hFFFF_FFFF; flush = 1'b0;
        mem_init = 1'b1; poke_en = 1'b0; poke_addr = '0; poke_data = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = initPat(i);

        // Reset: outputs forced to zero even with a request present
        @(negedge clk); @(negedge clk);
        #1;
        checkOutput("rst_stall", {31'b0, stall}, 32'd0);
        checkOutput("rst_dread", {31'b0, dmem_read}, 32'd0);
        checkOutput("rst_daddr", dmem_addr, 32'd0);
        checkOutput("rst_load", load_data, 32'd0);
        mem_init = 1'b0; mem_read = 1'b0; addr = 32'd0; wdata = 32'd0;
        @(negedge clk);
        rst = 1'b0;

        // Aligned LW
        poke(8'd0, 8'h80); poke(8'd1, 8'h7F); poke(8'd2, 8'h12); poke(8'd3, 8'h34);
        applyStimulus(1'b1, 1'b0, 3'd2, 32'd0, 32'd0);
        checkOutput("lw0_val", last_load, 32'h34127F80);
        checkOutput("lw0_cyc", 32'(last_cycles), 32'd1);

        // Misaligned halfword loads
        applyStimulus(1'b1, 1'b0, 3'd1, 32'd1, 32'd0);
`ifndef LSU_MISALIGN_TRAP_EN
        checkOutput("lh1_val", last_load, 32'h0000127F);
        checkOutput("lh1_cyc", 32'(last_cycles), 32'd2);
`endif
        poke(8'd1, 8'h00); poke(8'd2, 8'hF0);
        applyStimulus(1'b1, 1'b0, 3'd1, 32'd1, 32'd0);
`ifndef LSU_MISALIGN_TRAP_EN
        checkOutput("lh1_neg", last_load, 32'hFFFFF000);
`endif
        applyStimulus(1'b1, 1'b0, 3'd5, 32'd1, 32'd0);
`ifndef LSU_MISALIGN_TRAP_EN
        checkOutput("lhu1_val", last_load, 32'h0000F000);
`endif

        // Misaligned word store
        applyStimulus(1'b0, 1'b1, 3'd2, 32'd5, 32'hAABBCCDD);
`ifndef LSU_MISALIGN_TRAP_EN
        checkOutput("sw5_cyc", 32'(last_cycles), 32'd4);
        checkOutput("sw5_m5", {24'b0, mem[5]}, 32'hDD);
        checkOutput("sw5_m8", {24'b0, mem[8]}, 32'hAA);
`endif
        checkOutput("sw5_m4", {24'b0, mem[4]}, {24'b0, initPat(4)});
        checkOutput("sw5_m9", {24'b0, mem[9]}, {24'b0, initPat(9)});

        // Read and write together: the write wins
        applyStimulus(1'b1, 1'b1, 3'd0, 32'h40, 32'h0000005A);
        checkOutput("rw_m40", {24'b0, mem[8'h40]}, 32'h5A);

        // Invalid funct3: no access, zero result
        applyStimulus(1'b1, 1'b0, 3'd3, 32'd0, 32'd0);
        checkOutput("f3inv_load", last_load, 32'd0);

`ifndef LSU_MISALIGN_TRAP_EN
        // Flush in the third cycle of a split LW at addr 3
        @(negedge clk);
        mem_read = 1'b1; func3 = 3'd2; addr = 32'd3;
        #1 checkOutput("fl_c1_stall", {31'b0, stall}, 32'd1);
        @(negedge clk);
        #1 checkOutput("fl_c2_stall", {31'b0, stall}, 32'd1);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; mem_read = 1'b0; addr = 32'd0;
        #1;
        checkOutput("fl_stall", {31'b0, stall}, 32'd0);
        checkOutput("fl_dread", {31'b0, dmem_read}, 32'd0);
        checkOutput("fl_daddr", dmem_addr, 32'd0);
        applyStimulus(1'b1, 1'b0, 3'd2, 32'd3, 32'd0);

        // Reset pulse during a split SW at k=2
        @(negedge clk);
        mem_write = 1'b1; func3 = 3'd2; addr = 32'h21; wdata = 32'h11223344;
        @(negedge clk);
        @(negedge clk);
        #1 checkOutput("rs_k2_addr", dmem_addr, 32'h23);
        rst = 1'b1;
        #1;
        checkOutput("rs_dwrite", {31'b0, dmem_write}, 32'd0);
        checkOutput("rs_stall", {31'b0, stall}, 32'd0);
        checkOutput("rs_daddr", dmem_addr, 32'd0);
        @(negedge clk);
        rst = 1'b0; mem_write = 1'b0; addr = 32'd0; wdata = 32'd0; func3 = 3'd0;
        #1;
        checkOutput("rs_m21", {24'b0, mem[8'h21]}, 32'h44);
        checkOutput("rs_m22", {24'b0, mem[8'h22]}, 32'h33);
        checkOutput("rs_m23", {24'b0, mem[8'h23]}, {24'b0, initPat(8'h23)});
        checkOutput("rs_m24", {24'b0, mem[8'h24]}, {24'b0, initPat(8'h24)});
        ref_mem[8'h21] = 8'h44; ref_mem[8'h22] = 8'h33;

        // Address wrap at the top of the address space
        applyStimulus(1'b0, 1'b1, 3'd2, 32'hFFFF_FFFE, 32'hDEADBEEF);
        checkOutput("wr_m00", {24'b0, mem[8'h00]}, 32'hAD);
        checkOutput("wr_m01", {24'b0, mem[8'h01]}, 32'hDE);
        applyStimulus(1'b1, 1'b0, 3'd2, 32'hFFFF_FFFE, 32'd0);
        checkOutput("wr_lw", last_load, 32'hDEADBEEF);
`else
        // Trap mode: misaligned LW is refused
        applyStimulus(1'b1, 1'b0, 3'd2, 32'd2, 32'd0);
        checkOutput("trap_load", last_load, 32'd0);
        applyStimulus(1'b0, 1'b1, 3'd2, 32'd6, 32'h01020304);
        checkOutput("trap_m6", {24'b0, mem[6]}, {24'b0, ref_mem[6]});
`endif

        // Randomized traffic against the reference
        for (int n = 0; n < 80; n++) begin
            f3 = f3_tab[$urandom_range(0, 9)];
            wr = ($urandom_range(0, 2) == 0);
            rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
            if (wr && (f3 == 3'd4 || f3 == 3'd5)) f3 = f3 - 3'd4;
            r = $urandom_range(0, 3);
            applyStimulus(rd, wr, f3, (r == 0) ? $urandom() : 32'($urandom_range(0, 255)), $urandom());
        end

        // Whole memory image against the shadow copy
        diffs = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) diffs++;
        checkOutput("memimg", 32'(diffs), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-stage front end that sits between the EX/MEM pipeline register and `DataMemory` in the pipelined RV32I core. Aligned loads and stores pass straight through in one cycle. Misaligned halfword and word accesses are split into sequential byte accesses, with a pipeline stall raised until the last byte. It also assembles and extends split load data before handing it to the MEM/WB register.

## Interface
Parameters:
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, data width; fixed at 32, no other value supported.

Ports:
- `clk`  in  1  core clock; one clock domain.
- `rst`  in  1  asynchronous, active-high reset.
- `mem_read`  in  1  load request from EX/MEM.
- `mem_write`  in  1  store request from EX/MEM.
- `func3`  in  3  RV32I load/store funct3.
- `addr`  in  32  byte address.
- `wdata`  in  32  store data (rs2).
- `flush`  in  1  abandon any split access in progress.
- `dmem_read`  out  1  to `DataMemory.MemRead`.
- `dmem_write`  out  1  to `DataMemory.MemWrite`.
- `dmem_func3`  out  3  to `DataMemory.func3`.
- `dmem_addr`  out  32  to `DataMemory.addr`.
- `dmem_wdata`  out  32  to `DataMemory.data_in`.
- `dmem_rdata`  in  32  from `DataMemory.data_out`; combinational read.
- `load_data`  out  32  extended load result to MEM/WB.
- `stall`  out  1  freezes PC, IF/ID, ID/EX and EX/MEM.
- `misalign_err`  out  1  misaligned access trapped; only with the macro defined.

## Operation
Request decode:
- Word accesses are misaligned when `addr[1:0]≠0`.
- Halfword accesses are misaligned when `addr[0]=1`.
- Byte accesses are never misaligned.
- If `mem_write` and `mem_read` are both high, the write wins and the read is ignored.
- `func3` values 3, 6 and 7 issue no access: `load_data`=0, no stall.

Aligned requests (IDLE state):
- Pure combinational pass-through: `dmem_*` = request fields.
- `load_data` = `dmem_rdata`.
- `stall`=0.

FSM states: IDLE, SPLIT.

IDLE → SPLIT, on a misaligned request:
- Latch `addr`, `func3`, `wdata` and the write flag.
- Set byte count `n` = 2 (halfword) or 4 (word).
- Set index `k` = 0.
- Issue byte 0 in the same cycle.

In SPLIT:
- `dmem_addr` = latched addr + k.
- `dmem_func3` = 4 (LBU) for loads, 0 (SB) for stores.
- `dmem_wdata[7:0]` = latched `wdata[8k+7:8k]`.
- Loads capture `dmem_rdata[7:0]` into byte lane k of the assembly register at each edge.
- `k` increments every cycle.

SPLIT → IDLE after the cycle with k=n-1. In that final cycle:
- `load_data` = extension of {current byte, assembled bytes} per latched `func3` (LH sign-extends, LHU zero-extends, LW passes through).

`flush` in SPLIT:
- Return to IDLE at the next edge.
- Bytes already written stay written; no rollback.
- The assembly register clears.

Address arithmetic is modulo 2^32. A word at 0xFFFFFFFE wraps its bytes to 0x00000000 and 0x00000001.

## Timing
- Reset values: state IDLE, k=0, assembly register 0, latched fields 0. While `rst` is high, all outputs are forced to 0.
- Aligned access: 0 stall cycles; result is valid in the same cycle.
- Misaligned access of n bytes:
  - Total n cycles.
  - `stall`=1 for the first n-1 cycles and 0 in the last, so the pipeline advances at the end of cycle n.
- Stores are committed by `DataMemory` at each posedge, one byte per cycle.
- While `stall`=1, EX/MEM holds its request. The unit uses only latched values in SPLIT and ignores input changes.
- Reset mid-SPLIT: immediate return to IDLE. Partial writes remain.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - No splitting and SPLIT is unused.
  - A misaligned request drives `dmem_read`=`dmem_write`=0, `load_data`=0 and `stall`=0.
  - `misalign_err`=1 combinationally for that cycle.
- Undefined: splitting as described; `misalign_err` is tied to 0.

## Structure
- `lsu_pkg` holds:
  - funct3 constants `F3_LB`=0, `F3_LH`=1, `F3_LW`=2, `F3_LBU`=4, `F3_LHU`=5;
  - the state type (IDLE, SPLIT);
  - byte-count helper constants.
- Sub-module `lsu_load_extend`: combinational sign/zero extension from a 32-bit assembled value and `func3`. Shared by the split path only; the aligned path relies on `DataMemory` extension.

## Test plan
- Memory preloaded 0x80 0x7F 0x12 0x34 at 0..3. LW addr 0: `load_data`=0x34127F80, `stall` never high.
- LH addr 1, bytes at 1..2 = 0x7F, 0x12:
  - `stall`=1 for 1 cycle;
  - `load_data`=0x0000127F;
  - with bytes 0x00, 0xF0 the result is 0xFFFFF000, and LHU gives 0x0000F000.
- SW 0xAABBCCDD addr 5: 4 cycles, `stall` high 3 cycles; mem[5..8] = DD CC BB AA; mem[4] and mem[9] unchanged.
- LW addr 3 with `flush` asserted after cycle 2: back to IDLE next cycle, `stall`=0, assembly register=0.
- `rst` pulsed during SW split at k=2: outputs 0 immediately; mem[addr], mem[addr+1] written, mem[addr+2..3] untouched.
- With `LSU_MISALIGN_TRAP_EN`: LW addr 2 → `misalign_err`=1, `dmem_read`=0, `stall`=0, memory unchanged.
